// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : shared op encodings, pointer select indices and SP defaults
// Rev 1.0
// ============================================================================
package mem_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'd0,
        OP_LOAD     = 3'd1,
        OP_POST_INC = 3'd2,
        OP_PRE_DEC  = 3'd3,
        OP_PUSH     = 3'd4,
        OP_POP      = 3'd5,
        OP_LOAD_LO  = 3'd6,
        OP_LOAD_HI  = 3'd7
    } op_e;

    localparam int SEL_X    = 0;
    localparam int SEL_Y    = 1;
    localparam int SEL_Z    = 2;
    localparam int SEL_SP   = 3;
    localparam int NUM_PTRS = 4;

    localparam logic [3:0]  SEL_SP_ONEHOT    = 4'b1000;
    localparam logic [15:0] SP_RESET_DEFAULT = 16'hFFFF;
    localparam logic [15:0] SP_LIMIT_DEFAULT = 16'hFF00;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ptr_reg.sv
`default_nettype none
// ============================================================================
// ptr_reg : 16-bit pointer register with load / byte-load / inc / dec controls
// Rev 1.0
// ============================================================================
module ptr_reg #(
    parameter logic [15:0] RESET_VAL = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        load_i,
    input  logic        load_lo_i,
    input  logic        load_hi_i,
    input  logic        inc_i,
    input  logic        dec_i,
    input  logic [15:0] data_i,
    output logic [15:0] value_o
);

    logic [15:0] value_q;
    logic [15:0] value_d;

    // Byte loads take their byte from data_i[7:0] regardless of the lane written.
    always_comb begin
        value_d = value_q;
        if (load_i) begin
            value_d = data_i;
        end else if (load_lo_i) begin
            value_d[7:0] = data_i[7:0];
        end else if (load_hi_i) begin
            value_d[15:8] = data_i[7:0];
        end else if (inc_i) begin
            value_d = value_q + 16'd1;
        end else if (dec_i) begin
            value_d = value_q - 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            value_q <= RESET_VAL;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule
`default_nettype wire

// File: rtl/mem_ptr_regs.sv
`default_nettype none
// ============================================================================
// mem_ptr_regs : X/Y/Z/SP address pointers with effective-address generation
// Rev 1.0
// ============================================================================
module mem_ptr_regs
    import mem_pkg::*;
#(
    parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT,
    parameter logic [15:0] SP_LIMIT = SP_LIMIT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic        stall,
    input  logic [3:0]  ptr_sel,
    input  logic [2:0]  op,
    input  logic [15:0] load_data,
    input  logic        clr_flags,
    output logic [15:0] x_ptr,
    output logic [15:0] y_ptr,
    output logic [15:0] z_ptr,
    output logic [15:0] stack_ptr,
    output logic [3:0]  mem_sel,
    output logic        sel_error,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    op_e  w_op;
    logic w_is_stack_op;
    logic w_is_mem_op;
    logic w_sel_ok;
    logic w_req_ok;
    logic w_accept;

    assign w_op          = op_e'(op);
    assign w_is_stack_op = (w_op == OP_PUSH) || (w_op == OP_POP);
    assign w_is_mem_op   = (w_op == OP_POST_INC) || (w_op == OP_PRE_DEC) || w_is_stack_op;
    assign w_sel_ok      = is_onehot4(ptr_sel) && (!w_is_stack_op || (ptr_sel == SEL_SP_ONEHOT));
    // Address outputs track the request even under stall; only the update waits.
    assign w_req_ok      = in_valid && w_sel_ok;
    assign w_accept      = w_req_ok && !stall;

    logic [15:0] ptr_val  [NUM_PTRS];
    logic [15:0] ptr_addr [NUM_PTRS];

    for (genvar i = 0; i < NUM_PTRS; i++) begin : g_ptr
        logic w_tgt_req;
        logic w_tgt_wr;

        assign w_tgt_req = w_req_ok && ptr_sel[i];
        assign w_tgt_wr  = w_accept && ptr_sel[i];

        ptr_reg #(
            .RESET_VAL ((i == SEL_SP) ? SP_RESET : 16'h0000)
        ) u_ptr (
            .clk_i     (clock),
            .rst_ni    (reset_n),
            .load_i    (w_tgt_wr && (w_op == OP_LOAD)),
            .load_lo_i (w_tgt_wr && (w_op == OP_LOAD_LO)),
            .load_hi_i (w_tgt_wr && (w_op == OP_LOAD_HI)),
            .inc_i     (w_tgt_wr && ((w_op == OP_POST_INC) || (w_op == OP_POP))),
            .dec_i     (w_tgt_wr && ((w_op == OP_PRE_DEC) || (w_op == OP_PUSH))),
            .data_i    (load_data),
            .value_o   (ptr_val[i])
        );

        assign ptr_addr[i] = !w_tgt_req               ? ptr_val[i] :
                             (w_op == OP_PRE_DEC)     ? ptr_val[i] - 16'd1 :
                             (w_op == OP_POP)         ? ptr_val[i] + 16'd1 :
                                                        ptr_val[i];
    end

    logic ovf_q, ovf_d;
    logic unf_q, unf_d;

    always_comb begin
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (!stall) begin
            if (clr_flags) begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end else begin
                if (w_accept && (w_op == OP_PUSH) && (ptr_val[SEL_SP] == SP_LIMIT)) begin
                    ovf_d = 1'b1;
                end
                if (w_accept && (w_op == OP_POP) && (ptr_val[SEL_SP] == SP_RESET)) begin
                    unf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign x_ptr           = ptr_addr[SEL_X];
    assign y_ptr           = ptr_addr[SEL_Y];
    assign z_ptr           = ptr_addr[SEL_Z];
    assign stack_ptr       = ptr_addr[SEL_SP];
    assign mem_sel         = (reset_n && w_req_ok && w_is_mem_op) ? ptr_sel : 4'b0000;
    assign sel_error       = reset_n && in_valid && !w_sel_ok;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_ptr_regs.sv
`default_nettype none
// ============================================================================
// tb_mem_ptr_regs : scoreboard bench with a behavioural pointer model
// Rev 1.0
// ============================================================================
module tb_mem_ptr_regs;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;
    logic [3:0]  ptr_sel = 4'd0;
    logic [2:0]  op = 3'd0;
    logic [15:0] load_data = 16'd0;
    logic        clr_flags = 1'b0;
    logic [15:0] x_ptr, y_ptr, z_ptr, stack_ptr;
    logic [3:0]  mem_sel;
    logic        sel_error, stack_overflow, stack_underflow;

    mem_ptr_regs dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .in_valid        (in_valid),
        .stall           (stall),
        .ptr_sel         (ptr_sel),
        .op              (op),
        .load_data       (load_data),
        .clr_flags       (clr_flags),
        .x_ptr           (x_ptr),
        .y_ptr           (y_ptr),
        .z_ptr           (z_ptr),
        .stack_ptr       (stack_ptr),
        .mem_sel         (mem_sel),
        .sel_error       (sel_error),
        .stack_overflow  (stack_overflow),
        .stack_underflow (stack_underflow)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [15:0] s;
        logic [3:0]  ms;
        logic        se;
        logic        ov;
        logic        un;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Architectural state of the model and the state due after the next edge.
    logic [15:0] m_p [4] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    logic [15:0] n_p [4] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    logic        m_ov = 1'b0, m_un = 1'b0, n_ov = 1'b0, n_un = 1'b0;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic step(input bit rn, input bit v, input bit st, input logic [3:0] sel,
                        input logic [2:0] o, input logic [15:0] d, input bit clr);
        exp_t        e;
        logic [15:0] a [4];
        bit          legal, vr;
        @(posedge clock);
        m_p = n_p; m_ov = n_ov; m_un = n_un;
        @(negedge clock);
        reset_n = rn; in_valid = v; stall = st; ptr_sel = sel; op = o;
        load_data = d; clr_flags = clr;
        if (!rn) begin
            m_p = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
            m_ov = 1'b0; m_un = 1'b0;
        end
        legal = ($countones(sel) == 1) && !((o == 3'd4 || o == 3'd5) && sel != 4'b1000);
        vr    = v && legal;
        for (int i = 0; i < 4; i++) begin
            a[i] = m_p[i];
            if (vr && sel[i] && o == 3'd3) a[i] = m_p[i] - 16'd1;
            if (vr && sel[i] && o == 3'd5) a[i] = m_p[i] + 16'd1;
        end
        e.x  = a[0]; e.y = a[1]; e.z = a[2]; e.s = a[3];
        e.ms = (rn && vr && o >= 3'd2 && o <= 3'd5) ? sel : 4'b0000;
        e.se = rn && v && !legal;
        e.ov = m_ov;
        e.un = m_un;
        exp_q.push_back(e);
        n_p = m_p; n_ov = m_ov; n_un = m_un;
        if (rn && !st) begin
            if (vr) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) begin
                        case (o)
                            3'd1: n_p[i] = d;
                            3'd2, 3'd5: n_p[i] = m_p[i] + 16'd1;
                            3'd3, 3'd4: n_p[i] = m_p[i] - 16'd1;
                            3'd6: n_p[i] = {m_p[i][15:8], d[7:0]};
                            3'd7: n_p[i] = {d[7:0], m_p[i][7:0]};
                            default: ;
                        endcase
                    end
                end
            end
            if (clr) begin
                n_ov = 1'b0; n_un = 1'b0;
            end else begin
                if (vr && o == 3'd4 && m_p[3] == 16'hFF00) n_ov = 1'b1;
                if (vr && o == 3'd5 && m_p[3] == 16'hFFFF) n_un = 1'b1;
            end
        end
    endtask

    task automatic nop();
        step(1, 0, 0, 4'b0000, 3'd0, 16'h0000, 0);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("x_ptr", x_ptr, e.x);
                cmp("y_ptr", y_ptr, e.y);
                cmp("z_ptr", z_ptr, e.z);
                cmp("stack_ptr", stack_ptr, e.s);
                cmp("mem_sel", {12'd0, mem_sel}, {12'd0, e.ms});
                cmp("sel_error", {15'd0, sel_error}, {15'd0, e.se});
                cmp("stack_overflow", {15'd0, stack_overflow}, {15'd0, e.ov});
                cmp("stack_underflow", {15'd0, stack_underflow}, {15'd0, e.un});
            end
        end
    end

    initial begin
        logic [3:0]  sel;
        logic [2:0]  o;
        logic [15:0] d;
        bit          st, clr, rn;
        int          r;

        step(0, 0, 0, 4'b0000, 3'd0, 16'h0000, 0);
        step(0, 0, 0, 4'b0000, 3'd0, 16'h0000, 0);
        #3 cmp("reset stack_ptr", stack_ptr, 16'hFFFF);

        // POP straight out of reset wraps SP and flags underflow
        step(1, 1, 0, 4'b1000, 3'd5, 16'h0000, 0);
        #3 cmp("pop stack_ptr", stack_ptr, 16'h0000);
        nop();
        #3 cmp("pop underflow", {15'd0, stack_underflow}, 16'd1);

        step(1, 1, 0, 4'b0001, 3'd1, 16'h1234, 0);
        step(1, 1, 0, 4'b0001, 3'd2, 16'h0000, 0);
        #3 cmp("postinc x_ptr", x_ptr, 16'h1234);
        cmp("postinc mem_sel", {12'd0, mem_sel}, 16'h0001);
        nop();
        #3 cmp("postinc x after", x_ptr, 16'h1235);

        step(1, 1, 0, 4'b0010, 3'd3, 16'h0000, 0);
        #3 cmp("predec y_ptr", y_ptr, 16'hFFFF);
        nop();
        #3 cmp("predec y after", y_ptr, 16'hFFFF);

        step(1, 0, 0, 4'b0000, 3'd0, 16'h0000, 1);
        step(1, 1, 0, 4'b1000, 3'd1, 16'hFF00, 0);
        step(1, 1, 0, 4'b1000, 3'd4, 16'h0000, 0);
        #3 cmp("push stack_ptr", stack_ptr, 16'hFF00);
        nop();
        #3 cmp("push sp after", stack_ptr, 16'hFEFF);
        cmp("push overflow", {15'd0, stack_overflow}, 16'd1);
        nop();
        step(1, 0, 0, 4'b0000, 3'd0, 16'h0000, 1);
        #3 cmp("overflow sticky", {15'd0, stack_overflow}, 16'd1);
        nop();
        #3 cmp("overflow cleared", {15'd0, stack_overflow}, 16'd0);

        step(1, 1, 0, 4'b0010, 3'd4, 16'h0000, 0);
        #3 cmp("bad push sel_error", {15'd0, sel_error}, 16'd1);
        step(1, 1, 0, 4'b0110, 3'd2, 16'h0000, 0);
        #3 cmp("bad sel sel_error", {15'd0, sel_error}, 16'd1);
        cmp("bad sel mem_sel", {12'd0, mem_sel}, 16'd0);
        nop();
        #3 cmp("bad sel y unchanged", y_ptr, 16'hFFFF);

        step(1, 1, 0, 4'b0100, 3'd1, 16'h0010, 0);
        repeat (3) begin
            step(1, 1, 1, 4'b0100, 3'd2, 16'h0000, 0);
            #3 cmp("stall z_ptr", z_ptr, 16'h0010);
            cmp("stall mem_sel", {12'd0, mem_sel}, 16'h0004);
        end
        step(1, 1, 0, 4'b0100, 3'd2, 16'h0000, 0);
        nop();
        #3 cmp("stall release z", z_ptr, 16'h0011);
        step(1, 1, 0, 4'b0100, 3'd1, 16'h0010, 0);
        step(1, 1, 1, 4'b0100, 3'd2, 16'h0000, 0);
        step(0, 1, 1, 4'b0100, 3'd2, 16'h0000, 0);
        #3 cmp("reset mid-stall z", z_ptr, 16'h0000);
        nop();

        for (int k = 0; k < 600; k++) begin
            r   = $urandom_range(0, 9);
            sel = (r < 8) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            o   = 3'($urandom_range(0, 7));
            if ((o == 3'd4 || o == 3'd5) && r < 6) sel = 4'b1000;
            case ($urandom_range(0, 5))
                0: d = 16'hFF00;
                1: d = 16'hFFFF;
                2: d = 16'h0000;
                default: d = 16'($urandom());
            endcase
            st  = ($urandom_range(0, 4) == 0);
            clr = !st && ($urandom_range(0, 9) == 0);
            rn  = ($urandom_range(0, 99) != 0);
            step(rn, ($urandom_range(0, 4) != 0), st, sel, o, d, clr);
        end
        nop();
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
        #5;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: %0d left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_ptr_regs.md
MEM_PTR_REGS -- requirements
Module: mem_ptr_regs

Interface
REQ-001 SHALL have parameter SP_RESET, default 16'hFFFF, stack pointer value after reset; stack grows downward.
REQ-002 SHALL have parameter SP_LIMIT, default 16'hFF00, lowest legal stack pointer value.
REQ-003 SHALL use one clock and an asynchronous active-low reset; ports: clock input 1, clock; reset_n input 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid input 1, high when op/ptr_sel/load_data form a valid request.
REQ-005 SHALL have port stall input 1, pipeline hold; no register changes while high.
REQ-006 SHALL have port ptr_sel input 4, one-hot target select: [0] X, [1] Y, [2] Z, [3] SP.
REQ-007 SHALL have port op input 3, operation code: 0 NOP, 1 LOAD, 2 POST_INC, 3 PRE_DEC, 4 PUSH, 5 POP, 6 LOAD_LO, 7 LOAD_HI.
REQ-008 SHALL have port load_data input 16, data for LOAD, LOAD_LO and LOAD_HI.
REQ-009 SHALL have port clr_flags input 1, synchronous clear of sticky flags.
REQ-010 SHALL have ports x_ptr, y_ptr, z_ptr, stack_ptr, each output 16, effective access address for the current request, feeding the memory address select stage.
REQ-011 SHALL have port mem_sel output 4, one-hot address select for the memory stage, equal to ptr_sel on an accepted memory op, else 0.
REQ-012 SHALL have ports sel_error output 1, stack_overflow output 1 and stack_underflow output 1.

Function
REQ-013 SHALL accept a request when in_valid=1, stall=0 and ptr_sel is exactly one-hot; registers update on that rising clock edge only.
REQ-014 SHALL, for LOAD, write load_data to the target; for LOAD_LO/LOAD_HI, write only bits [7:0]/[15:8] from load_data[7:0].
REQ-015 SHALL, for POST_INC, present the current value as the effective address and store value+1.
REQ-016 SHALL, for PRE_DEC, present value-1 combinationally as the effective address and store value-1.
REQ-017 SHALL accept PUSH/POP only with ptr_sel=4'b1000; PUSH presents SP and stores SP-1; POP presents SP+1 and stores SP+1.
REQ-018 SHALL use modulo-2^16 arithmetic: X/Y/Z wrap silently (16'hFFFF+1 -> 0, 0-1 -> 16'hFFFF).
REQ-019 SHALL set stack_overflow sticky on PUSH with SP==SP_LIMIT, SP still updating to SP-1.
REQ-020 SHALL set stack_underflow sticky on POP with SP==SP_RESET, SP still updating to SP+1.
REQ-021 SHALL treat any SP-affecting op other than PUSH/POP (LOAD, POST_INC, ...) without setting flags.
REQ-022 SHALL drive mem_sel=ptr_sel combinationally for ops 2..5 when the request is accepted; 0 for NOP/LOAD*/rejected.
REQ-023 SHALL, when in_valid=1 with ptr_sel not one-hot, or with PUSH/POP and ptr_sel!=4'b1000, pulse sel_error high for that cycle, register nothing and drive mem_sel=0.
REQ-024 SHALL, while stall=1, hold all registers and present the same effective addresses and mem_sel as if unstalled (hold-stable for the memory stage).
REQ-025 SHALL give clr_flags priority over flag set in the same cycle: flags clear.
REQ-026 SHALL present non-target pointers' registered values unmodified.

Reset
REQ-027 SHALL on reset_n low asynchronously set X, Y and Z to 0, SP to SP_RESET, and both flags to 0; sel_error and mem_sel are 0 while reset_n is low.
REQ-028 SHALL discard a request in flight on reset; first accept is the first rising edge with reset_n high.

Structure
REQ-029 SHALL place op encodings, ptr_sel bit indices and SP_RESET/SP_LIMIT defaults in shared package mem_pkg.
REQ-030 SHALL implement the four pointers as one sub-module instance each of ptr_reg (16-bit register with load/lo/hi/inc/dec controls); SP flag logic stays in the top.

Verification
REQ-031 SHALL test: after reset, LOAD X=16'h1234 then POST_INC X -> x_ptr=16'h1234, mem_sel=4'b0001, next cycle x_ptr=16'h1235.
REQ-032 SHALL test: PRE_DEC Y with Y=0 -> y_ptr=16'hFFFF same cycle, Y register 16'hFFFF after edge, no flags.
REQ-033 SHALL test: LOAD SP=16'hFF00, PUSH -> stack_ptr=16'hFF00, SP=16'hFEFF, stack_overflow=1 sticky until clr_flags.
REQ-034 SHALL test: POP directly after reset -> stack_ptr=16'h0000 (SP_RESET+1 wraps), stack_underflow=1.
REQ-035 SHALL test: PUSH with ptr_sel=4'b0010, and POST_INC with ptr_sel=4'b0110 -> sel_error=1, mem_sel=0, all pointers unchanged.
REQ-036 SHALL test: POST_INC Z=16'h0010 with stall=1 for 3 cycles -> z_ptr stays 16'h0010, mem_sel=4'b0100 held; Z=16'h0011 after release; reset_n low mid-stall -> Z=0.
